fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 8'h00, PC value loaded on reset; bits [1:0] SHALL be 0.
REQ-002 Parameter INSTR_W, default 32, instruction word width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 imem_addr  output  8  instruction memory address; combinationally equal to current PC.
REQ-006 imem_rdata  input  INSTR_W  instruction word at imem_addr, valid in the same cycle.
REQ-007 branch_valid  input  1  redirect request from execute.
REQ-008 branch_target  input  8  redirect address; bits [1:0] ignored, treated as 0.
REQ-009 out_valid  output  1  head of the output queue holds a fetched instruction.
REQ-010 out_ready  input  1  downstream (decode / pipeline register) accepts the head this cycle.
REQ-011 out_pc  output  8  PC of the head entry.
REQ-012 out_instr  output  INSTR_W  instruction word of the head entry.

Function
REQ-013 Block SHALL hold an 8-bit PC register and a 2-entry FIFO of {pc, instr} pairs with a 2-bit count (0..2).
REQ-014 pop SHALL occur when out_valid && out_ready && !branch_valid.
REQ-015 push SHALL occur when !branch_valid && (count < 2 || pop).
REQ-016 On push, the FIFO SHALL store {PC, imem_rdata} at the tail and PC SHALL advance by 4.
REQ-017 With no push, PC SHALL hold its value.
REQ-018 PC arithmetic SHALL be 8-bit modulo: 8'hFC + 4 -> 8'h00, no error flag.
REQ-019 count SHALL update as count + push - pop; simultaneous push and pop at count 2 SHALL leave count at 2 with the head advanced.
REQ-020 out_valid SHALL equal (count != 0); out_pc/out_instr SHALL show the head entry, head first-in first-out.
REQ-021 Latency: instruction fetched at edge N SHALL appear on out_* in the cycle after edge N when the FIFO was empty.
REQ-022 branch_valid SHALL take priority over push and pop: count <= 0, PC <= {branch_target[7:2], 2'b00}, no push, no pop that cycle.
REQ-023 First instruction after a redirect SHALL be the target, visible on out_* one cycle after the fetch at the target (two cycles after the branch edge).
REQ-024 out_* SHALL be stable while out_valid && !out_ready (no branch).
REQ-025 With count 2 and out_ready low, imem_addr SHALL remain at the next unfetched PC and no entry SHALL be overwritten.

Reset
REQ-026 On rst high at a clock edge: PC <= RESET_PC, count <= 0, FIFO storage <= 0, overriding branch_valid, push and pop.
REQ-027 After reset, out_valid SHALL be 0, out_pc 8'h00, out_instr 0 until the first push.
REQ-028 Reset asserted mid-stream SHALL discard all queued entries; no entry fetched before reset SHALL appear afterwards.

Verification
REQ-029 Reset with RESET_PC=0, out_ready=1, imem_rdata=f(addr) -> out_pc 0x00,0x04,0x08,... one per cycle, out_valid high from the 2nd cycle after reset release.
REQ-030 out_ready=0 for 5 cycles from reset -> count saturates at 2, imem_addr holds 0x08, out_pc held at 0x00; release -> 0x00,0x04,0x08 in order, no gaps/duplicates.
REQ-031 branch_valid=1, branch_target=0x43 while count=2 -> next cycle out_valid=0, imem_addr=0x40; following cycle out_pc=0x40.
REQ-032 PC at 0xF8, out_ready=1 -> out_pc sequence 0xF8, 0xFC, 0x00, 0x04.
REQ-033 Count 2, out_ready=1 -> one pop and one push per cycle, count stays 2, throughput 1/cycle.
REQ-034 rst asserted while count=2 and branch_valid=1 -> next cycle PC=RESET_PC, out_valid=0, no stale pc emitted.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory port, branch redirect and the
// valid/ready output handshake toward decode.
interface fetch_stage_if #(
  parameter int INSTR_W = 32
);
  logic [7:0]         imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               branch_valid;
  logic [7:0]         branch_target;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_pc;
  logic [INSTR_W-1:0] out_instr;

  // master: the fetch stage itself
  modport master (
    output imem_addr,
    input  imem_rdata,
    input  branch_valid,
    input  branch_target,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr
  );

  // slave: memory, execute and decode around the fetch stage
  modport slave (
    input  imem_addr,
    output imem_rdata,
    output branch_valid,
    output branch_target,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: 8-bit PC driving a combinational instruction memory,
// feeding a 2-entry {pc, instr} FIFO toward decode, with branch redirect.
module fetch_stage #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         INSTR_W  = 32
) (
  input  logic           clk,
  input  logic           rst,
  fetch_stage_if.master  bus
);

  function automatic logic [7:0] pc_advance(input logic [7:0] pc);
    return pc + 8'd4;
  endfunction

  function automatic logic [7:0] align_word(input logic [7:0] addr);
    return {addr[7:2], 2'b00};
  endfunction

  logic [7:0]         pc_p0;
  logic [1:0]         count_p1;
  logic               head_p1;
  logic [7:0]         pc_q_p1    [2];
  logic [INSTR_W-1:0] instr_q_p1 [2];

  logic vld_p1;
  logic pop;
  logic push;
  logic wr_idx;

  assign vld_p1 = (count_p1 != 2'd0);

  always_comb begin
    pop    = vld_p1 && bus.out_ready && !bus.branch_valid;
    push   = !bus.branch_valid && ((count_p1 != 2'd2) || pop);
    // Tail slot: the one after head when one entry is queued, otherwise head
    // itself (empty queue, or full queue whose head leaves this cycle).
    wr_idx = head_p1 ^ (count_p1 == 2'd1);
  end

  assign bus.imem_addr = pc_p0;
  assign bus.out_valid = vld_p1;
  assign bus.out_pc    = pc_q_p1[head_p1];
  assign bus.out_instr = instr_q_p1[head_p1];

  // Stage p0 -> p1: fetch at PC, enqueue {PC, word}, dequeue toward decode
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0    <= RESET_PC;
      count_p1 <= 2'd0;
      head_p1  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        pc_q_p1[i]    <= 8'h00;
        instr_q_p1[i] <= '0;
      end
    end else if (bus.branch_valid) begin
      pc_p0    <= align_word(bus.branch_target);
      count_p1 <= 2'd0;
    end else begin
      if (push) begin
        pc_q_p1[wr_idx]    <= pc_p0;
        instr_q_p1[wr_idx] <= bus.imem_rdata;
        pc_p0              <= pc_advance(pc_p0);
      end
      if (pop) begin
        head_p1 <= ~head_p1;
      end
      count_p1 <= count_p1 + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-cycle vector table plus hand sequences, with a
// scoreboard of the expected in-order instruction stream checked on every handshake.
module tb_fetch_stage;
  localparam int         INSTR_W  = 32;
  localparam logic [7:0] RESET_PC = 8'h00;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if #(.INSTR_W(INSTR_W)) bus ();

  fetch_stage #(.RESET_PC(RESET_PC), .INSTR_W(INSTR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'h3C};
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic       r;
    logic       bv;
    logic [7:0] bt;
    logic       rdy;
    logic       chk;
    logic       ev;
    logic [7:0] eaddr;
    logic       chk_pc;
    logic [7:0] epc;
  } vec_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   hs_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic refill(input logic [7:0] start);
    logic [7:0] p;
    exp_t       e;
    p = start & 8'hFC;
    sb.delete();
    for (int i = 0; i < 64; i++) begin
      e.pc    = p;
      e.instr = mem_word(p);
      sb.push_back(e);
      p = p + 8'd4;
    end
  endtask

  // Drive one cycle's inputs, then score any handshake that will complete at the next edge.
  task automatic cycle(input logic r, input logic bv, input logic [7:0] bt, input logic rdy);
    exp_t e;
    @(negedge clk);
    rst               = r;
    bus.branch_valid  = bv;
    bus.branch_target = bt;
    bus.out_ready     = rdy;
    #1;
    if (!r && !bv && rdy && (bus.out_valid === 1'b1)) begin
      hs_cnt++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_empty: got pc %h expected no output", bus.out_pc);
      end else begin
        e = sb.pop_front();
        check("sb_pc", {24'h0, bus.out_pc}, {24'h0, e.pc});
        check("sb_instr", bus.out_instr, e.instr);
      end
    end
    if (r) refill(RESET_PC);
    else if (bv) refill(bt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[12];
  int   hs0;
  logic [7:0] a0;

  initial begin
    rst               = 1'b1;
    bus.branch_valid  = 1'b0;
    bus.branch_target = 8'h00;
    bus.out_ready     = 1'b0;

    //          r   bv  bt     rdy chk ev  eaddr  chkpc epc
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 1'b1, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h08, 1'b1, 8'h04};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h0C, 1'b1, 8'h04};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h0C, 1'b1, 8'h04};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h0C, 1'b1, 8'h04};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h10, 1'b1, 8'h08};
    tbl[8]  = '{1'b0, 1'b1, 8'h43, 1'b1, 1'b1, 1'b1, 8'h14, 1'b1, 8'h0C};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h40, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1, 8'h40};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h48, 1'b1, 8'h44};

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].r, tbl[i].bv, tbl[i].bt, tbl[i].rdy);
      if (tbl[i].chk) begin
        check($sformatf("tbl%0d_valid", i), {31'h0, bus.out_valid}, {31'h0, tbl[i].ev});
        check($sformatf("tbl%0d_addr", i), {24'h0, bus.imem_addr}, {24'h0, tbl[i].eaddr});
        if (tbl[i].chk_pc)
          check($sformatf("tbl%0d_pc", i), {24'h0, bus.out_pc}, {24'h0, tbl[i].epc});
      end
    end

    // Stall from reset: queue fills to 2, fetch address parks at 0x08
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check("rst_instr", bus.out_instr, 32'h0);
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check("stall_valid", {31'h0, bus.out_valid}, 32'h1);
    check("stall_addr", {24'h0, bus.imem_addr}, 32'h08);
    check("stall_pc", {24'h0, bus.out_pc}, 32'h00);
    check("stall_instr", bus.out_instr, mem_word(8'h00));
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Reset beats a simultaneous branch with a full queue
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 8'h80, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check("rstbr_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rstbr_addr", {24'h0, bus.imem_addr}, {24'h0, RESET_PC});
    check("rstbr_pc", {24'h0, bus.out_pc}, 32'h00);
    check("rstbr_instr", bus.out_instr, 32'h0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // PC wrap: branch to 0xF8 then stream through 0x00
    cycle(1'b0, 1'b1, 8'hF8, 1'b1);
    hs0 = hs_cnt;
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("wrap_handshakes", 32'(hs_cnt - hs0), 32'd5);

    // Full queue streaming: one pop and one push every cycle
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    hs0 = hs_cnt;
    a0  = bus.imem_addr;
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      check($sformatf("thru%0d_valid", k), {31'h0, bus.out_valid}, 32'h1);
      check($sformatf("thru%0d_addr", k), {24'h0, bus.imem_addr}, {24'h0, a0 + 8'(4 * k)});
    end
    check("thru_handshakes", 32'(hs_cnt - hs0), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
